adc_sampler: RTL and testbench
==============================

# adc_sampler

Sample-rate sequencer and averager that sits directly downstream of the `spi2adc` converter and feeds the address/step counter stage. It generates its own sample tick from the system clock. On each tick it pulses `start` to the ADC and waits for the converted 10-bit word. It accumulates 2^AVG_LOG2 conversions and emits one averaged sample with a single-cycle valid strobe. Stalled or overrun conversions are flagged in sticky error bits rather than corrupting the output.

## Interface
Parameters:
- `TICK_DIV`, 5000: sysclk cycles per sample tick (50 MHz / 5000 = 10 kHz); legal range 2..65535.
- `AVG_LOG2`, 2: log2 of conversions averaged per output sample; legal range 0..4.
- `TIMEOUT`, 1023: max sysclk cycles spent waiting for `adc_valid` after `adc_start`.

Ports:
- `sysclk`, in, 1: 50 MHz system clock, the only clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `adc_start`, out, 1: one-cycle start pulse to `spi2adc`.
- `adc_data`, in, 10: conversion result from `spi2adc`.
- `adc_valid`, in, 1: `spi2adc` data_valid, active high; only its rising edge is used.
- `sample`, out, 10: averaged sample, held between updates.
- `sample_valid`, out, 1: one-cycle strobe, high in the cycle `sample` updates.
- `tick`, out, 1: one-cycle sample tick, for use by downstream stages.
- `timeout_err`, out, 1: sticky flag for a conversion timeout.
- `overrun_err`, out, 1: sticky flag for a tick arriving while not IDLE.
- `clear_err`, in, 1: synchronous clear of both sticky flags.

## Operation
- Reset values: all outputs 0, tick counter 0, accumulator 0, sample count 0, FSM in IDLE, `adc_valid` edge register 0.
- Tick counter: counts 0..TICK_DIV-1 and wraps. `tick` is high in the cycle the count equals TICK_DIV-1.
- FSM states:
  - IDLE: on `tick`, go to START.
  - START: assert `adc_start` for 1 cycle, clear the timeout counter, go to WAIT.
  - WAIT: on a rising edge of `adc_valid` (current high, registered previous low), go to ACC. If the timeout counter reaches TIMEOUT first, set `timeout_err`, discard the accumulator and sample count, and return to IDLE.
  - ACC: add `adc_data` to the accumulator and increment the sample count. If the count reaches 2^AVG_LOG2, load `sample` with accumulator >> AVG_LOG2 (truncating), pulse `sample_valid`, and clear the accumulator and count. Then return to IDLE.
- Arithmetic: accumulator is 10+AVG_LOG2 bits unsigned and cannot overflow. The sample count is AVG_LOG2+1 bits wide.
- Overrun: if `tick` occurs while the FSM is not in IDLE, the tick is dropped and `overrun_err` is set. The in-flight conversion continues.
- Simultaneous events: if `clear_err` and an error-setting event occur in the same cycle, set wins.
- Reset mid-conversion: everything returns to reset values immediately. A late `adc_valid` edge from the abandoned conversion is ignored, because the FSM is in IDLE.

## Timing
- `adc_start` rises 1 cycle after `tick`.
- ACC is entered 1 cycle after the `adc_valid` rising edge is seen. `sample` and `sample_valid` update at the end of that ACC cycle.
- Latency from the final conversion's `adc_valid` edge to `sample_valid`: 2 cycles.
- Minimum TICK_DIV for overrun-free operation: `spi2adc` conversion time + 4 cycles.

## Configuration
- `ADC_SAMPLER_AVG_EN` defined: averaging as described.
- `ADC_SAMPLER_AVG_EN` not defined:
  - AVG_LOG2 is ignored and no accumulator is synthesized.
  - Each ACC loads `adc_data` directly into `sample` and pulses `sample_valid`, so there is one output per conversion.

## Structure
- `adc_sampler_pkg` holds:
  - the FSM state enum (IDLE, START, WAIT, ACC);
  - `ADC_W` = 10;
  - the default parameter constants.
- Sub-module `sample_tick_gen` (parameter TICK_DIV; ports `sysclk`, `rst_n`, `tick`) holds the tick counter. The FSM, edge detector, accumulator and error flags live in the top level.

## Test plan
- Reset release, TICK_DIV=20, ADC model returns 0x200 → first `adc_start` at cycle 20; no `sample_valid` until the 4th conversion; then `sample`=0x200.
- AVG_LOG2=2, conversions 0x001, 0x002, 0x003, 0x3FF → `sample`=0x101 (1029>>2), one `sample_valid` pulse.
- ADC model never asserts `adc_valid`, TIMEOUT=50 → `timeout_err` set 50 cycles after `adc_start`; FSM back in IDLE; next tick starts a new conversion.
- TICK_DIV=10, ADC conversion takes 30 cycles → `overrun_err` set; every result still accumulates correctly.
- Assert `rst_n` low in WAIT, release, then a stale `adc_valid` edge arrives → no accumulation; outputs stay 0.
- Build without `ADC_SAMPLER_AVG_EN`, conversion 0x155 → `sample`=0x155 with `sample_valid` 2 cycles after the `adc_valid` edge.

Source files
------------

// File: rtl/adc_sampler_pkg.sv
// Shared constants and FSM encoding for the adc_sampler sample sequencer/averager.
package adc_sampler_pkg;

  localparam int unsigned ADC_W        = 10;
  localparam int unsigned TICK_DIV_DEF = 5000;
  localparam int unsigned AVG_LOG2_DEF = 2;
  localparam int unsigned TIMEOUT_DEF  = 1023;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    ACC
  } state_t;

endpackage

// File: rtl/adc_sampler_sample_tick_gen.sv
// Free-running divider producing a one-cycle sample tick every TICK_DIV sysclk cycles.
module sample_tick_gen
  import adc_sampler_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == CNT_W'(TICK_DIV - 1)) ? '0 : cnt + CNT_W'(1);
  end

  // tick is registered against the next count so it is high while cnt == TICK_DIV-1
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CNT_W'(TICK_DIV - 1));
    end
  end

endmodule

// File: rtl/adc_sampler.sv
// Sample-rate sequencer for spi2adc: ticks, starts conversions, averages results, flags stalls/overruns.
// Define ADC_SAMPLER_AVG_EN to average 2^AVG_LOG2 conversions; otherwise every conversion is output.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             sysclk,
  input  logic             rst_n,
  output logic             adc_start,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic [ADC_W-1:0] sample,
  output logic             sample_valid,
  output logic             tick,
  output logic             timeout_err,
  output logic             overrun_err,
  input  logic             clear_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_t          state;
  logic            valid_q;
  logic            valid_rise;
  logic [TO_W-1:0] to_cnt;

  sample_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign valid_rise = adc_valid & ~valid_q;

`ifdef ADC_SAMPLER_AVG_EN
  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned AVG_N = 1 << AVG_LOG2;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] n_acc;
  logic [CNT_W-1:0] n_acc_inc;

  always_comb begin
    acc_sum   = acc + ACC_W'(adc_data);
    n_acc_inc = n_acc + CNT_W'(1);
  end
`else
  // AVG_LOG2 has no effect when averaging is compiled out
  if (AVG_LOG2 != 0) begin : g_avg_log2_ignored
  end
`endif

  // to_cnt counts cycles since adc_start rose; it is zero during START
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid_q      <= 1'b0;
      to_cnt       <= '0;
      adc_start    <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
`ifdef ADC_SAMPLER_AVG_EN
      acc          <= '0;
      n_acc        <= '0;
`endif
    end else begin
      valid_q      <= adc_valid;
      adc_start    <= 1'b0;
      sample_valid <= 1'b0;

      if (clear_err) begin
        timeout_err <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (tick && (state != IDLE)) begin
        overrun_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            state     <= START;
            adc_start <= 1'b1;
            to_cnt    <= '0;
          end
        end
        START: begin
          to_cnt <= to_cnt + TO_W'(1);
          state  <= WAIT;
        end
        WAIT: begin
          if (valid_rise) begin
            state <= ACC;
          end else if (to_cnt >= TO_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
`ifdef ADC_SAMPLER_AVG_EN
            acc         <= '0;
            n_acc       <= '0;
`endif
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ACC: begin
`ifdef ADC_SAMPLER_AVG_EN
          if (n_acc_inc == CNT_W'(AVG_N)) begin
            sample       <= ADC_W'(acc_sum >> AVG_LOG2);
            sample_valid <= 1'b1;
            acc          <= '0;
            n_acc        <= '0;
          end else begin
            acc   <= acc_sum;
            n_acc <= n_acc_inc;
          end
`else
          sample       <= adc_data;
          sample_valid <= 1'b1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// Randomized bench for adc_sampler with a behavioural spi2adc responder and averaging scoreboard.
module tb_adc_sampler;

  localparam int unsigned TICK_DIV = 20;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned TIMEOUT  = 50;
`ifdef ADC_SAMPLER_AVG_EN
  localparam int unsigned N_AVG = 1 << AVG_LOG2;
`else
  localparam int unsigned N_AVG = 1;
`endif

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       adc_start;
  logic [9:0] adc_data;
  logic       adc_valid;
  logic [9:0] sample;
  logic       sample_valid;
  logic       tick;
  logic       timeout_err;
  logic       overrun_err;
  logic       clear_err;

  adc_sampler #(
    .TICK_DIV(TICK_DIV),
    .AVG_LOG2(AVG_LOG2),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .adc_start   (adc_start),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .sample      (sample),
    .sample_valid(sample_valid),
    .tick        (tick),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .clear_err   (clear_err)
  );

  always #10 sysclk = ~sysclk;

  typedef struct {
    int unsigned val;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned data_q[$];
  int unsigned checks     = 0;
  int unsigned errors     = 0;
  int unsigned rc         = 0;
  int unsigned epoch      = 0;
  int unsigned pend_sum   = 0;
  int unsigned pend_n     = 0;
  int unsigned n_seen     = 0;
  int unsigned conv_delay = 8;
  bit          rand_delay = 1'b0;
  bit          respond    = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (rc=%0d)", tag, got, exp, rc);
    end
  endtask

  // An accepted conversion joins the running average; every N_AVG makes one output
  task automatic accept(input int unsigned v, input int unsigned edge_cyc);
    exp_t e;
    pend_sum += v;
    pend_n++;
    if (pend_n == N_AVG) begin
      e.val = pend_sum / N_AVG;
      e.cyc = edge_cyc + 2;
      exp_q.push_back(e);
      pend_sum = 0;
      pend_n   = 0;
    end
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n = 1'b0;
    epoch++;
    pend_sum = 0;
    pend_n   = 0;
    exp_q.delete();
    repeat (n) @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(output int unsigned s);
    s = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sysclk);
      if (adc_start === 1'b1) begin
        s = rc;
        return;
      end
    end
    check_eq("start_wait_expired", adc_start, 1);
  endtask

  task automatic wait_until(input int unsigned c);
    for (int i = 0; i < 1000 && rc < c; i++) @(negedge sysclk);
  endtask

  // cycles since reset release
  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) rc <= 0;
    else        rc <= rc + 1;
  end

  // spi2adc responder: answers each start after a delay with a 2-cycle valid pulse
  initial begin
    int unsigned s, d, v, ep;
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(negedge sysclk);
      if (rst_n === 1'b1 && adc_start === 1'b1) begin
        s  = rc;
        ep = epoch;
        d  = rand_delay ? $urandom_range(15, 1) : conv_delay;
        if (!respond) begin
          pend_sum = 0;
          pend_n   = 0;
        end else begin
          v = (data_q.size() != 0) ? data_q.pop_front() : $urandom_range(1023, 0);
          repeat (d) @(negedge sysclk);
          adc_data  = 10'(v);
          adc_valid = 1'b1;
          if (ep == epoch && d < TIMEOUT) accept(v, s + d);
          repeat (2) @(negedge sysclk);
          adc_valid = 1'b0;
        end
      end
    end
  end

  // output monitor: tick cadence and scoreboard of averaged samples
  always @(negedge sysclk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      check_eq("tick", tick, 32'((rc % TICK_DIV) == TICK_DIV - 1));
      if (sample_valid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", sample_valid, 0);
        end else begin
          e = exp_q.pop_front();
          n_seen++;
          check_eq("sample", sample, e.val);
          check_eq("valid_cycle", rc, e.cyc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= rc) begin
        check_eq("missed_valid", sample_valid, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned s, s2;
    rst_n     = 1'b0;
    clear_err = 1'b0;
    foreach (data_q[i]) data_q.delete(i);
    repeat (4) data_q.push_back(10'h200);
    data_q.push_back(10'h001);
    data_q.push_back(10'h002);
    data_q.push_back(10'h003);
    data_q.push_back(10'h3FF);
    repeat (4) data_q.push_back(10'h155);
    repeat (3) @(negedge sysclk);
    check_eq("rst_adc_start", adc_start, 0);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_sample_valid", sample_valid, 0);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    check_eq("rst_overrun_err", overrun_err, 0);
    rst_n = 1'b1;

    wait_start(s);
    check_eq("first_start_cycle", s, TICK_DIV);
    repeat (300) @(negedge sysclk);
    check_eq("nominal_timeout_err", timeout_err, 0);
    check_eq("nominal_overrun_err", overrun_err, 0);

    rand_delay = 1'b1;
    repeat (600) @(negedge sysclk);
    rand_delay = 1'b0;
    conv_delay = 8;
    check_eq("random_timeout_err", timeout_err, 0);
    check_eq("random_overrun_err", overrun_err, 0);

    // stalled conversion; clear held across the set cycle must lose
    respond = 1'b0;
    wait_start(s);
    wait_until(s + 45);
    clear_err = 1'b1;
    wait_until(s + TIMEOUT - 1);
    check_eq("timeout_early", timeout_err, 0);
    @(negedge sysclk);
    check_eq("timeout_set_wins", timeout_err, 1);
    @(negedge sysclk);
    check_eq("timeout_cleared", timeout_err, 0);
    clear_err = 1'b0;
    respond   = 1'b1;
    wait_start(s2);
    check_eq("restart_after_timeout", s2, s + 3 * TICK_DIV);

    // conversions longer than the tick period
    conv_delay = 30;
    repeat (240) @(negedge sysclk);
    check_eq("overrun_set", overrun_err, 1);
    check_eq("overrun_no_timeout", timeout_err, 0);
    conv_delay = 8;
    repeat (80) @(negedge sysclk);
    clear_err = 1'b1;
    @(negedge sysclk);
    clear_err = 1'b0;
    repeat (60) @(negedge sysclk);
    check_eq("overrun_cleared", overrun_err, 0);

    // reset while waiting; the abandoned conversion's valid edge arrives afterwards
    conv_delay = 12;
    wait_start(s);
    conv_delay = 8;
    wait_until(s + 3);
    do_reset(4);
    repeat (4) data_q.push_back(10'h155);
    repeat (18) @(negedge sysclk);
    check_eq("stale_sample", sample, 0);
    check_eq("stale_sample_valid", sample_valid, 0);
    check_eq("stale_timeout_err", timeout_err, 0);
    check_eq("stale_overrun_err", overrun_err, 0);

    repeat (200) @(negedge sysclk);
    check_eq("outputs_produced", 32'(n_seen > 10), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
